float_cmp_pipe: RTL and testbench
=================================

# float_cmp_pipe

Pipelined, parametrised sign-magnitude floating-point comparator with a valid/ready stream interface. It generalises the team's fixed 16-bit combinational float comparator in three ways: configurable exponent and mantissa widths, correct ordering of negative operands and signed zeros, and optional NaN detection. It also adds per-transaction compare/min/max modes. It sits in the datapath between operand producers and sorting/selection logic, sustaining one comparison per cycle under backpressure.

## Interface
- EXP_W, 4, exponent field width
- MAN_W, 11, mantissa field width
- NAN_EN, 1, 1 = exponent all-ones with nonzero mantissa is NaN (unordered); 0 = no NaN decode
- (derived) W = 1+EXP_W+MAN_W; operand layout {sign, exp, man}, sign in MSB
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand pair offered
- in_ready  out  1  block accepts pair this cycle
- in_a  in  W  operand a
- in_b  in  W  operand b
- in_mode  in  2  00 compare, 01 min, 10 max, 11 treated as compare
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_aopb  out  3  one-hot relation: [2] a==b, [1] a>b, [0] a<b; 000 when unordered
- out_res  out  W  compare: a; min: smaller; max: larger; ties and unordered: a
- out_unord  out  1  either operand NaN (only when NAN_EN=1)

## Operation
- Zero: exp==0 and man==0; +0 and -0 compare equal.
- Ordering, in priority order:
  - unordered (NAN_EN and either operand NaN);
  - both zero gives eq;
  - signs differ gives the positive operand greater;
  - both positive: unsigned compare of {exp,man};
  - both negative: reversed unsigned compare of {exp,man}.
- Exactly one aopb bit is set for ordered results; all zero with out_unord=1 for unordered results.
- Transfer occurs on a valid&&ready cycle at either port. Order is preserved; nothing is dropped or duplicated.
- Two register stages:
  - S1 registers the operands, mode, decoded zero/NaN flags, sign relation and magnitude relation.
  - S2 registers out_aopb, out_res and out_unord.
- Enables:
  - en2 = !s2_valid || out_ready
  - en1 = !s1_valid || en2
  - in_ready = en1, combinational from out_ready.
- A stage's data registers load only when its enable is high and its upstream is valid. Otherwise they hold, so out_* stays stable while out_valid && !out_ready.

## Timing
- Latency: 2 cycles from accept to out_valid when unstalled; throughput 1 per cycle.
- Reset (rst_n low, asynchronous):
  - s1_valid=0, out_valid=0, out_aopb=000, out_res=0, out_unord=0.
  - in_ready reads 1, but inputs are ignored until rst_n is high at a rising edge.
- Reset mid-operation: in-flight pairs are discarded immediately. There is no partial output.
- Full (both stages valid, out_ready low): in_ready=0.
- Simultaneous out_ready and in_valid while full: S2 drains, S1 moves to S2 and the new pair enters S1 in the same cycle, so there is no bubble.
- in_mode is sampled with the operands. A change while stalled does not affect pairs already accepted.

## Structure
- Package float_cmp_pkg:
  - mode constants (MODE_CMP, MODE_MIN, MODE_MAX);
  - aopb bit indices (AOPB_EQ=2, AOPB_GT=1, AOPB_LT=0);
  - functions is_zero and is_nan, parametrised by EXP_W/MAN_W.
- Sub-module fp_mag_cmp: combinational unsigned {exp,man} comparator producing eq/gt/lt. It is instantiated once, in S1.

## Test plan
- Positive ordering, mode 00: a=0x4000, b=0x3800 -> aopb=010, res=0x4000, out_valid 2 cycles after accept.
- Negative ordering, mode 01: a=0xC000, b=0xB800 -> aopb=001, res=0xC000. Mode 10 with the same operands -> res=0xB800.
- Signed zero and ties: a=0x0000, b=0x8000 -> aopb=100, unord=0. Mode 01 with a=b=0x1234 -> res=a.
- NaN:
  - NAN_EN=1, a=0x7801, b=0x0000 -> aopb=000, unord=1, res=0x7801.
  - NAN_EN=0, same operands -> aopb=010, unord=0.
- Backpressure: 4 back-to-back pairs with out_ready low for 3 cycles.
  - in_ready drops after 2 accepts.
  - out_* stays stable while stalled.
  - All 4 results emerge in order with no loss.
  - Random valid/ready stress is checked against a reference model.
- Reset mid-stream: assert rst_n low with 2 pairs in flight -> out_valid=0 and outputs zero within the same cycle. After release, a fresh pair yields the correct result 2 cycles after accept.

Source files
------------

// File: rtl/float_cmp_pkg.sv
// Shared mode encodings, relation bit positions and field-decode helpers
// for the pipelined sign-magnitude float comparator.
package float_cmp_pkg;

  typedef enum logic [1:0] {
    MODE_CMP  = 2'b00,
    MODE_MIN  = 2'b01,
    MODE_MAX  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int AOPB_EQ = 2;
  localparam int AOPB_GT = 1;
  localparam int AOPB_LT = 0;

  // Callers zero-extend their exp/man fields to this width, so one helper
  // serves every EXP_W/MAN_W combination up to 32 bits per field.
  localparam int FIELD_W = 32;

  function automatic logic is_zero(input logic [FIELD_W-1:0] expField,
                                   input logic [FIELD_W-1:0] manField);
    return (expField == '0) && (manField == '0);
  endfunction

  function automatic logic is_nan(input logic [FIELD_W-1:0] expField,
                                  input logic [FIELD_W-1:0] manField,
                                  input int                 expW);
    logic [FIELD_W-1:0] allOnes;
    allOnes = (FIELD_W'(1) << expW) - FIELD_W'(1);
    return (expField == allOnes) && (manField != '0);
  endfunction

endpackage

// File: rtl/fp_mag_cmp.sv
// Combinational unsigned comparator over the {exp,man} magnitude field.
module fp_mag_cmp #(
  parameter int MAG_W = 15
) (
  input  logic [MAG_W-1:0] a_i,
  input  logic [MAG_W-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/float_cmp_pipe.sv
// Two-stage valid/ready float comparator: S1 captures operands plus decoded
// flags and magnitude relation, S2 resolves the ordered relation and min/max.
module float_cmp_pipe #(
  parameter int EXP_W  = 4,
  parameter int MAN_W  = 11,
  parameter bit NAN_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_aopb,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic                   out_unord
);

  import float_cmp_pkg::*;

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int MAG_W = EXP_W + MAN_W;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    mode_e        mode;
    logic         zeroA;
    logic         zeroB;
    logic         nanA;
    logic         nanB;
    logic         signDiff;
    logic         magEq;
    logic         magGt;
    logic         magLt;
  } s1_t;

  s1_t          s1In, s1_d, s1_q;
  logic         s1Valid_d, s1Valid_q;
  logic         outValid_d, outValid_q;
  logic [2:0]   aopb_d, aopb_q, relAopb;
  logic [W-1:0] res_d, res_q, relRes;
  logic         unord_d, unord_q, relUnord;
  logic         en1, en2;
  logic         magEq, magGt, magLt;

  // A stage may advance when it is empty or its downstream is advancing.
  assign en2      = !outValid_q || out_ready;
  assign en1      = !s1Valid_q || en2;
  assign in_ready = en1;

  fp_mag_cmp #(.MAG_W(MAG_W)) u_magCmp (
    .a_i  (in_a[MAG_W-1:0]),
    .b_i  (in_b[MAG_W-1:0]),
    .eq_o (magEq),
    .gt_o (magGt),
    .lt_o (magLt)
  );

  always_comb begin
    s1In          = '0;
    s1In.a        = in_a;
    s1In.b        = in_b;
    s1In.mode     = mode_e'(in_mode);
    s1In.zeroA    = is_zero(FIELD_W'(in_a[MAG_W-1:MAN_W]), FIELD_W'(in_a[MAN_W-1:0]));
    s1In.zeroB    = is_zero(FIELD_W'(in_b[MAG_W-1:MAN_W]), FIELD_W'(in_b[MAN_W-1:0]));
    s1In.nanA     = NAN_EN && is_nan(FIELD_W'(in_a[MAG_W-1:MAN_W]), FIELD_W'(in_a[MAN_W-1:0]), EXP_W);
    s1In.nanB     = NAN_EN && is_nan(FIELD_W'(in_b[MAG_W-1:MAN_W]), FIELD_W'(in_b[MAN_W-1:0]), EXP_W);
    s1In.signDiff = in_a[W-1] ^ in_b[W-1];
    s1In.magEq    = magEq;
    s1In.magGt    = magGt;
    s1In.magLt    = magLt;
  end

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1_d      = s1_q;
    if (en1) s1Valid_d = in_valid;
    if (en1 && in_valid) s1_d = s1In;
  end

  // Negative operands reverse the magnitude order; any zero pair ties.
  always_comb begin
    relAopb  = '0;
    relUnord = s1_q.nanA || s1_q.nanB;
    relRes   = s1_q.a;
    if (relUnord) begin
      relAopb = '0;
    end else if (s1_q.zeroA && s1_q.zeroB) begin
      relAopb[AOPB_EQ] = 1'b1;
    end else if (s1_q.signDiff) begin
      if (s1_q.a[W-1]) relAopb[AOPB_LT] = 1'b1;
      else             relAopb[AOPB_GT] = 1'b1;
    end else if (!s1_q.a[W-1]) begin
      relAopb = {s1_q.magEq, s1_q.magGt, s1_q.magLt};
    end else begin
      relAopb = {s1_q.magEq, s1_q.magLt, s1_q.magGt};
    end
    case (s1_q.mode)
      MODE_MIN: if (relAopb[AOPB_GT]) relRes = s1_q.b;
      MODE_MAX: if (relAopb[AOPB_LT]) relRes = s1_q.b;
      default:  relRes = s1_q.a;
    endcase
  end

  always_comb begin
    outValid_d = outValid_q;
    aopb_d     = aopb_q;
    res_d      = res_q;
    unord_d    = unord_q;
    if (en2) outValid_d = s1Valid_q;
    if (en2 && s1Valid_q) begin
      aopb_d  = relAopb;
      res_d   = relRes;
      unord_d = relUnord;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1_q       <= '0;
      outValid_q <= 1'b0;
      aopb_q     <= '0;
      res_q      <= '0;
      unord_q    <= 1'b0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1_q       <= s1_d;
      outValid_q <= outValid_d;
      aopb_q     <= aopb_d;
      res_q      <= res_d;
      unord_q    <= unord_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_aopb  = aopb_q;
  assign out_res   = res_q;
  assign out_unord = unord_q;

endmodule

// File: tb/tb_float_cmp_pipe.sv
// Bench for float_cmp_pipe: directed cases, backpressure, random stress against
// a value-based reference model, and asynchronous reset mid-stream.
module tb_float_cmp_pipe;

  localparam int W = 16;

  typedef struct packed {
    logic [2:0]   aopb;
    logic [W-1:0] res;
    logic         unord;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid, inReady, outReady;
  logic [W-1:0] inA, inB;
  logic [1:0]   inMode;
  logic         outValid, outUnord;
  logic [2:0]   outAopb;
  logic [W-1:0] outRes;
  logic         inReady2, outValid2, outUnord2;
  logic [2:0]   outAopb2;
  logic [W-1:0] outRes2;

  int testsRun    = 0;
  int testsFailed = 0;
  int popCount    = 0;
  int idx, cyc, pop0;
  exp_t expQ[$];
  exp_t expv;

  logic         sInReady, sOutValid, sOutUnord, sAccept, sUnord2, sOutValid2;
  logic [2:0]   sOutAopb, sAopb2;
  logic [W-1:0] sOutRes;

  logic [W-1:0] bpA[4];
  logic [W-1:0] bpB[4];
  logic [1:0]   bpM[4];

  always #5 clk = ~clk;

  float_cmp_pipe #(.EXP_W(4), .MAN_W(11), .NAN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .in_a(inA), .in_b(inB), .in_mode(inMode), .out_valid(outValid),
    .out_ready(outReady), .out_aopb(outAopb), .out_res(outRes), .out_unord(outUnord)
  );

  float_cmp_pipe #(.EXP_W(4), .MAN_W(11), .NAN_EN(1'b0)) dutNoNan (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady2),
    .in_a(inA), .in_b(inB), .in_mode(inMode), .out_valid(outValid2),
    .out_ready(outReady), .out_aopb(outAopb2), .out_res(outRes2), .out_unord(outUnord2)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=hang expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Orders operands by their signed numeric value rather than bit fields.
  function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] mode, input bit nanEn);
    exp_t r;
    int   va, vb;
    bit   na, nb;
    na = nanEn && (a[14:11] == 4'hF) && (a[10:0] != 11'h0);
    nb = nanEn && (b[14:11] == 4'hF) && (b[10:0] != 11'h0);
    r.res = a;
    if (na || nb) begin
      r.aopb  = 3'b000;
      r.unord = 1'b1;
      return r;
    end
    r.unord = 1'b0;
    va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
    vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
    r.aopb = (va == vb) ? 3'b100 : ((va > vb) ? 3'b010 : 3'b001);
    if (mode == 2'b01 && vb < va) r.res = b;
    if (mode == 2'b10 && vb > va) r.res = b;
    return r;
  endfunction

  function automatic logic [W-1:0] randOperand();
    logic [W-1:0] v;
    v = W'($urandom);
    case ($urandom_range(0, 5))
      0:       v = {v[15], 15'h0};
      1:       v = {v[15], 4'hF, v[10:1], 1'b1};
      2:       v = {v[15], 4'hF, 11'h0};
      default: v = v;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    testsRun++;
    assert (obs === expd) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Samples at the falling edge, scoreboards both handshakes, then steps past
  // the next rising edge so the caller can drive new inputs.
  task automatic tick();
    @(negedge clk);
    sInReady   = inReady;
    sOutValid  = outValid;
    sOutAopb   = outAopb;
    sOutRes    = outRes;
    sOutUnord  = outUnord;
    sOutValid2 = outValid2;
    sAopb2     = outAopb2;
    sUnord2    = outUnord2;
    sAccept    = rst_n && inValid && inReady;
    if (rst_n && outValid && outReady) begin
      popCount++;
      checkOutput("sb_pending", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        expv = expQ.pop_front();
        checkOutput("sb_aopb", 32'(outAopb), 32'(expv.aopb));
        checkOutput("sb_res", 32'(outRes), 32'(expv.res));
        checkOutput("sb_unord", 32'(outUnord), 32'(expv.unord));
      end
    end
    if (sAccept) expQ.push_back(refModel(inA, inB, inMode, 1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] mode, input logic [2:0] expAopb,
                               input logic [W-1:0] expRes, input logic expUnord);
    outReady = 1'b1;
    inA      = a;
    inB      = b;
    inMode   = mode;
    inValid  = 1'b1;
    tick();
    checkOutput({tag, "_accept"}, 32'(sAccept), 32'd1);
    inValid = 1'b0;
    inMode  = ~mode;
    inA     = ~a;
    tick();
    checkOutput({tag, "_valid_early"}, 32'(sOutValid), 32'd0);
    tick();
    checkOutput({tag, "_valid"}, 32'(sOutValid), 32'd1);
    checkOutput({tag, "_aopb"}, 32'(sOutAopb), 32'(expAopb));
    checkOutput({tag, "_res"}, 32'(sOutRes), 32'(expRes));
    checkOutput({tag, "_unord"}, 32'(sOutUnord), 32'(expUnord));
  endtask

  initial begin
    rst_n    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    inA      = '0;
    inB      = '0;
    inMode   = 2'b00;
    bpA = '{16'h3C00, 16'hBC00, 16'h0000, 16'h4400};
    bpB = '{16'hBC00, 16'hB800, 16'h8000, 16'h4800};
    bpM = '{2'b00, 2'b01, 2'b10, 2'b10};

    #1;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_aopb", 32'(outAopb), 32'd0);
    checkOutput("rst_res", 32'(outRes), 32'd0);
    checkOutput("rst_unord", 32'(outUnord), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus("pos_cmp", 16'h4000, 16'h3800, 2'b00, 3'b010, 16'h4000, 1'b0);
    applyStimulus("neg_min", 16'hC000, 16'hB800, 2'b01, 3'b001, 16'hC000, 1'b0);
    applyStimulus("neg_max", 16'hC000, 16'hB800, 2'b10, 3'b001, 16'hB800, 1'b0);
    applyStimulus("szero", 16'h0000, 16'h8000, 2'b00, 3'b100, 16'h0000, 1'b0);
    applyStimulus("tie_min", 16'h1234, 16'h1234, 2'b01, 3'b100, 16'h1234, 1'b0);
    applyStimulus("rsvd_mode", 16'h3800, 16'h4000, 2'b11, 3'b001, 16'h3800, 1'b0);
    applyStimulus("nan", 16'h7801, 16'h0000, 2'b00, 3'b000, 16'h7801, 1'b1);
    checkOutput("nonan_valid", 32'(sOutValid2), 32'd1);
    checkOutput("nonan_aopb", 32'(sAopb2), 32'b010);
    checkOutput("nonan_unord", 32'(sUnord2), 32'd0);

    idx  = 0;
    cyc  = 0;
    pop0 = popCount;
    while ((idx < 4 || expQ.size() > 0) && cyc < 40) begin
      if (idx < 4) begin
        inValid = 1'b1;
        inA     = bpA[idx];
        inB     = bpB[idx];
        inMode  = bpM[idx];
      end else begin
        inValid = 1'b0;
      end
      outReady = (cyc >= 4);
      tick();
      if (sAccept) idx++;
      if (cyc == 2 || cyc == 3) begin
        expv = refModel(bpA[0], bpB[0], bpM[0], 1'b1);
        checkOutput("bp_in_ready_full", 32'(sInReady), 32'd0);
        checkOutput("bp_accepts", 32'(idx), 32'd2);
        checkOutput("bp_out_valid", 32'(sOutValid), 32'd1);
        checkOutput("bp_stall_res", 32'(sOutRes), 32'(expv.res));
        checkOutput("bp_stall_aopb", 32'(sOutAopb), 32'(expv.aopb));
      end
      cyc++;
    end
    checkOutput("bp_accepted", 32'(idx), 32'd4);
    checkOutput("bp_pop_count", 32'(popCount - pop0), 32'd4);

    for (int i = 0; i < 400; i++) begin
      inA      = randOperand();
      inB      = ($urandom_range(0, 4) == 0) ? inA : randOperand();
      inMode   = 2'($urandom_range(0, 3));
      inValid  = ($urandom_range(0, 9) < 7);
      outReady = ($urandom_range(0, 9) < 6);
      tick();
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 50 && expQ.size() > 0; i++) tick();
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

    outReady = 1'b0;
    inValid  = 1'b1;
    inA      = 16'h4400;
    inB      = 16'h4000;
    inMode   = 2'b00;
    tick();
    inA = 16'hC400;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("mid_rst_aopb", 32'(outAopb), 32'd0);
    checkOutput("mid_rst_res", 32'(outRes), 32'd0);
    checkOutput("mid_rst_unord", 32'(outUnord), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(inReady), 32'd1);
    expQ.delete();
    tick();
    tick();
    rst_n    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    checkOutput("post_rst_idle1", 32'(sOutValid), 32'd0);
    tick();
    checkOutput("post_rst_idle2", 32'(sOutValid), 32'd0);
    applyStimulus("post_rst", 16'h4000, 16'h3800, 2'b10, 3'b010, 16'h4000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
